// File: rtl/key_cmd_pkg.sv
// Shared definitions for the keyboard command scheduler: command codes,
// mapped scan codes and the repeat FSM state encoding.
package key_cmd_pkg;

  localparam int unsigned CMD_W = 3;
  localparam int unsigned KEY_W = 9;

  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NONE  = 3'd0;
  localparam cmd_t CMD_UP    = 3'd1;
  localparam cmd_t CMD_LEFT  = 3'd2;
  localparam cmd_t CMD_DOWN  = 3'd3;
  localparam cmd_t CMD_RIGHT = 3'd4;
  localparam cmd_t CMD_ENTER = 3'd5;

  localparam logic [KEY_W-1:0] SC_W     = 9'h01D;
  localparam logic [KEY_W-1:0] SC_A     = 9'h01C;
  localparam logic [KEY_W-1:0] SC_S     = 9'h01B;
  localparam logic [KEY_W-1:0] SC_D     = 9'h023;
  localparam logic [KEY_W-1:0] SC_ENTER = 9'h05A;

  typedef logic [1:0] rpt_state_t;

  localparam rpt_state_t ST_IDLE   = 2'd0;
  localparam rpt_state_t ST_DELAY  = 2'd1;
  localparam rpt_state_t ST_REPEAT = 2'd2;

  // Extended-prefix codes carry bit 8 set and so never match a mapped key.
  function automatic cmd_t decode_key(input logic [KEY_W-1:0] code);
    case (code)
      SC_W:     return CMD_UP;
      SC_A:     return CMD_LEFT;
      SC_S:     return CMD_DOWN;
      SC_D:     return CMD_RIGHT;
      SC_ENTER: return CMD_ENTER;
      default:  return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_cmd_scheduler_if.sv
// Key event input and command output bundle of the keyboard command scheduler.
interface key_cmd_scheduler_if;
  import key_cmd_pkg::*;

  logic              key_valid;
  logic [KEY_W-1:0]  key_code;
  logic              key_make;
  logic              cmd_valid;
  logic              cmd_ready;
  cmd_t              cmd;
  cmd_t              held;
  logic              overflow;

  modport master (
    output key_valid, key_code, key_make, cmd_ready,
    input  cmd_valid, cmd, held, overflow
  );

  modport slave (
    input  key_valid, key_code, key_make, cmd_ready,
    output cmd_valid, cmd, held, overflow
  );

endinterface

// File: rtl/key_cmd_fifo.sv
// Command FIFO; a push while full is accepted when a pop happens the same cycle.
module key_cmd_fifo
  import key_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output cmd_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  cmd_t          mem [DEPTH];
  logic          do_pop_c;
  logic          do_push_c;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign head      = empty ? CMD_NONE : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Turns decoder key events into queued navigation commands with last-pressed-wins
// arbitration; typematic auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_cmd_scheduler
  import key_cmd_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  key_cmd_scheduler_if.slave bus
);

  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || FIFO_DEPTH < 2) begin : g_bad_params
    $error("key_cmd_scheduler: REPEAT_DELAY, REPEAT_PERIOD and FIFO_DEPTH must be >= 2");
  end

  cmd_t key_cmd_c;
  cmd_t push_data_c;
  cmd_t head;
  cmd_t held_q, held_n;
  logic ovf_q, ovf_n;
  logic press_c, release_c, tick_c, push_c, pop_c;
  logic full, empty;

  assign key_cmd_c   = decode_key(bus.key_code);
  assign press_c     = bus.key_valid && bus.key_make && (key_cmd_c != CMD_NONE);
  assign release_c   = bus.key_valid && !bus.key_make && (key_cmd_c != CMD_NONE)
                       && (key_cmd_c == held_q);
  assign pop_c       = !empty && bus.cmd_ready;
  // A press always wins the push slot; a repeat only fills an empty FIFO.
  assign push_c      = press_c || (tick_c && empty);
  assign push_data_c = press_c ? key_cmd_c : held_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  rpt_state_t       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Repeat timing; key events override whatever the counter decided.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    tick_c  = 1'b0;
    case (state_q)
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          tick_c  = 1'b1;
          state_n = ST_REPEAT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (cnt_q == PERIOD_LAST) begin
          tick_c = 1'b1;
          cnt_n  = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (press_c) begin
      state_n = (key_cmd_c == CMD_ENTER) ? ST_IDLE : ST_DELAY;
      cnt_n   = '0;
    end else if (release_c) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end
  end
`else
  assign tick_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= CMD_NONE;
      ovf_q  <= 1'b0;
    end else begin
      held_q <= held_n;
      ovf_q  <= ovf_n;
    end
  end

  always_comb begin
    held_n = held_q;
    ovf_n  = ovf_q;
    if (press_c) begin
      held_n = key_cmd_c;
      if (full && !pop_c) ovf_n = 1'b1;
    end else if (release_c) begin
      held_n = CMD_NONE;
    end
  end

  key_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign bus.cmd_valid = !empty;
  assign bus.cmd       = head;
  assign bus.held      = held_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Self-checking bench for key_cmd_scheduler against a queue-based reference model;
// repeat expectations follow KEY_REPEAT_EN.
module tb_key_cmd_scheduler;

  localparam int D     = 8;
  localparam int P     = 4;
  localparam int DEPTH = 4;

  localparam logic [8:0] K_W   = 9'h01D;
  localparam logic [8:0] K_A   = 9'h01C;
  localparam logic [8:0] K_S   = 9'h01B;
  localparam logic [8:0] K_D   = 9'h023;
  localparam logic [8:0] K_ENT = 9'h05A;
  localparam logic [8:0] K_NUL = 9'h000;

  logic clk = 1'b0;
  logic rst;

  key_cmd_scheduler_if bus ();

  key_cmd_scheduler #(
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q[$];
  int m_held;
  bit m_ovf;
  int cyc = 0;
  int anchor;

  function automatic int map_key(input logic [8:0] code);
    case (code)
      9'h01D:  return 1;
      9'h01C:  return 2;
      9'h01B:  return 3;
      9'h023:  return 4;
      9'h05A:  return 5;
      default: return 0;
    endcase
  endfunction

  // Repeat pushes fall at D, D+P, D+2P, ... edges after the press edge.
  function automatic bit rep_tick();
`ifdef KEY_REPEAT_EN
    int e;
    if (anchor < 0) return 1'b0;
    e = cyc - anchor;
    return (e == D) || (e > D && ((e - D) % P) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_cmd();
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_held = 0;
    m_ovf  = 1'b0;
    anchor = -1;
  endtask

  // Drive one cycle of inputs, advance the model over the edge, settle 1 time unit.
  task automatic step(input bit kv, input logic [8:0] code, input bit mk, input bit rdy);
    int kc;
    int pv;
    bit press, rel, pop, tick, do_push;
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.key_make  = mk;
    bus.cmd_ready = rdy;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      kc    = map_key(code);
      press = kv && mk && (kc != 0);
      rel   = kv && !mk && (kc != 0) && (kc == m_held);
      pop   = (q.size() > 0) && rdy;
      tick  = rep_tick();
      if (press) begin
        do_push = (q.size() < DEPTH) || pop;
        if (!do_push) m_ovf = 1'b1;
        pv = kc;
      end else begin
        do_push = tick && (q.size() == 0);
        pv = m_held;
      end
      if (pop) void'(q.pop_front());
      if (do_push) q.push_back(pv);
      if (press) begin
        m_held = kc;
        anchor = (kc == 5) ? -1 : cyc;
      end else if (rel) begin
        m_held = 0;
        anchor = -1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, K_NUL, 0, 0);
    step(0, K_NUL, 0, 0);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0b want 0", bus.cmd_valid); end
    checks++; if (bus.cmd !== 3'd0) begin errors++; $display("FAIL reset_cmd: got %0d want 0", bus.cmd); end
    checks++; if (bus.held !== 3'd0) begin errors++; $display("FAIL reset_held: got %0d want 0", bus.held); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow); end
    rst = 1'b0;
  endtask

  task automatic test_single_press();
    step(1, K_W, 1, 1);
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'd1) begin errors++; $display("FAIL single_press: got valid=%0b cmd=%0d want valid=1 cmd=1", bus.cmd_valid, bus.cmd); end
    checks++; if (bus.held !== 3'd1) begin errors++; $display("FAIL single_held: got %0d want 1", bus.held); end
    step(0, K_NUL, 0, 1);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL single_beat: got valid=%0b want 0", bus.cmd_valid); end
    step(1, K_W, 0, 1);
    checks++; if (bus.held !== 3'd0) begin errors++; $display("FAIL single_release: got held=%0d want 0", bus.held); end
  endtask

  task automatic test_repeat();
    int beats;
    int exp_beats;
`ifdef KEY_REPEAT_EN
    exp_beats = 3;
`else
    exp_beats = 0;
`endif
    step(1, K_W, 1, 1);
    beats = 0;
    for (int k = 1; k <= 18; k++) begin
      step(0, K_NUL, 0, 1);
      checks++; if (bus.cmd_valid !== (q.size() > 0)) begin errors++; $display("FAIL repeat_valid@%0d: got %0b want %0b", k, bus.cmd_valid, q.size() > 0); end
      if (bus.cmd_valid) begin
        beats++;
        checks++; if (bus.cmd !== 3'd1) begin errors++; $display("FAIL repeat_cmd@%0d: got %0d want 1", k, bus.cmd); end
      end
    end
    checks++; if (beats != exp_beats) begin errors++; $display("FAIL repeat_count: got %0d want %0d", beats, exp_beats); end
    step(1, K_W, 0, 1);
    checks++; if (bus.held !== 3'd0) begin errors++; $display("FAIL repeat_release_held: got %0d want 0", bus.held); end
    beats = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, K_NUL, 0, 1);
      if (bus.cmd_valid) beats++;
    end
    checks++; if (beats != 0) begin errors++; $display("FAIL repeat_after_release: got %0d beats want 0", beats); end
  endtask

  task automatic test_back_to_back();
    int exp_seq[4] = '{2, 3, 4, 5};
    step(1, K_W, 1, 0);
    step(1, K_A, 1, 0);
    step(1, K_S, 1, 0);
    step(1, K_D, 1, 0);
    step(1, K_ENT, 1, 1);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %0b want 0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'(exp_seq[i])) begin errors++; $display("FAIL b2b_drain[%0d]: got valid=%0b cmd=%0d want 1/%0d", i, bus.cmd_valid, bus.cmd, exp_seq[i]); end
      step(0, K_NUL, 0, 1);
    end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b want 0", bus.cmd_valid); end
    step(1, K_ENT, 0, 1);
  endtask

  task automatic test_overflow();
    step(1, K_W, 1, 0);
    step(1, K_A, 1, 0);
    step(1, K_S, 1, 0);
    step(1, K_D, 1, 0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b want 0", bus.overflow); end
    step(1, K_ENT, 1, 0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", bus.overflow); end
    checks++; if (bus.held !== 3'd5) begin errors++; $display("FAIL ovf_held: got %0d want 5", bus.held); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'(i + 1)) begin errors++; $display("FAIL ovf_drain[%0d]: got valid=%0b cmd=%0d want 1/%0d", i, bus.cmd_valid, bus.cmd, i + 1); end
      step(0, K_NUL, 0, 1);
    end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b want 0", bus.cmd_valid); end
    step(1, K_ENT, 0, 1);
  endtask

  task automatic test_arbitration();
    step(1, K_W, 1, 1);
    step(0, K_NUL, 0, 1);
    step(1, K_D, 1, 1);
    checks++; if (bus.held !== 3'd4) begin errors++; $display("FAIL arb_last_wins: got %0d want 4", bus.held); end
    step(0, K_NUL, 0, 1);
    step(1, K_W, 0, 1);
    checks++; if (bus.held !== 3'd4) begin errors++; $display("FAIL arb_stale_release: got %0d want 4", bus.held); end
    step(1, K_D, 0, 1);
    checks++; if (bus.held !== 3'd0) begin errors++; $display("FAIL arb_release: got %0d want 0", bus.held); end
    step(0, K_NUL, 0, 1);
  endtask

  task automatic test_enter_hold();
    int beats;
    step(1, K_ENT, 1, 1);
    beats = 0;
    if (bus.cmd_valid) beats++;
    checks++; if (bus.cmd !== 3'd5) begin errors++; $display("FAIL enter_cmd: got %0d want 5", bus.cmd); end
    for (int k = 0; k < 20; k++) begin
      step(0, K_NUL, 0, 1);
      if (bus.cmd_valid) beats++;
    end
    checks++; if (beats != 1) begin errors++; $display("FAIL enter_once: got %0d beats want 1", beats); end
    checks++; if (bus.held !== 3'd5) begin errors++; $display("FAIL enter_held: got %0d want 5", bus.held); end
    step(1, K_ENT, 0, 1);
  endtask

  task automatic test_random();
    logic [8:0] codes [8] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h05A, 9'h11D, 9'h029, 9'h15A};
    bit kv, mk, rdy;
    logic [8:0] code;
    for (int k = 0; k < 600; k++) begin
      kv   = ($urandom_range(0, 9) == 0);
      code = codes[$urandom_range(0, 7)];
      mk   = ($urandom_range(0, 2) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      step(kv, code, mk, rdy);
      checks++; if (bus.cmd_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid@%0d: got %0b want %0b", k, bus.cmd_valid, q.size() > 0); end
      checks++; if (bus.cmd !== 3'(exp_cmd())) begin errors++; $display("FAIL rand_cmd@%0d: got %0d want %0d", k, bus.cmd, exp_cmd()); end
      checks++; if (bus.held !== 3'(m_held)) begin errors++; $display("FAIL rand_held@%0d: got %0d want %0d", k, bus.held, m_held); end
      checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow@%0d: got %0b want %0b", k, bus.overflow, m_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    step(1, K_W, 1, 0);
    step(1, K_A, 1, 0);
    step(1, K_S, 1, 0);
    step(1, K_D, 1, 0);
    step(1, K_W, 1, 0);
    step(0, K_NUL, 0, 1);
    step(0, K_NUL, 0, 1);
    for (int k = 0; k < 10; k++) step(0, K_NUL, 0, 0);
    checks++; if (bus.overflow !== 1'b1 || bus.cmd_valid !== 1'b1 || bus.cmd !== 3'(exp_cmd())) begin errors++; $display("FAIL rstmid_pre: got ovf=%0b valid=%0b cmd=%0d want 1/1/%0d", bus.overflow, bus.cmd_valid, bus.cmd, exp_cmd()); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd !== 3'd0) begin errors++; $display("FAIL rstmid_fifo: got valid=%0b cmd=%0d want 0/0", bus.cmd_valid, bus.cmd); end
    checks++; if (bus.held !== 3'd0) begin errors++; $display("FAIL rstmid_held: got %0d want 0", bus.held); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %0b want 0", bus.overflow); end
    model_reset();
    step(0, K_NUL, 0, 1);
    rst = 1'b0;
    step(1, K_W, 1, 1);
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'd1 || bus.held !== 3'd1) begin errors++; $display("FAIL rstmid_press: got valid=%0b cmd=%0d held=%0d want 1/1/1", bus.cmd_valid, bus.cmd, bus.held); end
    step(0, K_NUL, 0, 1);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_beat: got %0b want 0", bus.cmd_valid); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 9'h000;
    bus.key_make  = 1'b0;
    bus.cmd_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_repeat();
    test_back_to_back();
    test_overflow();
    test_arbitration();
    test_enter_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
